timer_core: RTL and testbench
=============================

// Module: timer_core
// PURPOSE
//  Parametrised successor of the single-field seconds counter: prescaler plus cascaded sec/min/hour
//  fields, up (stopwatch) or down (countdown) mode, synchronous load/clear, overflow and done reporting.
//  Sits between the board clock and the display/alarm logic; one instance per independent timer.
// PARAMETERS
//  CLK_HZ    32_000_000  input clock frequency; DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
//  TICK_HZ   1           field update rate (1 = real seconds)
//  SEC_MOD   60          seconds modulus; SEC_W = $clog2(SEC_MOD)
//  MIN_MOD   60          minutes modulus; MIN_W = $clog2(MIN_MOD)
//  HR_MOD    24          hours modulus;   HR_W  = $clog2(HR_MOD)
// PORTS
//  mclk           in   1      system clock, all logic on posedge
//  rst_n          in   1      synchronous reset, active low
//  enable         in   1      1 = prescaler advances; 0 = everything holds
//  mode           in   1      0 = count up, 1 = count down
//  clear          in   1      synchronous clear of prescaler, fields, done
//  load           in   1      synchronous load of fields from load_*
//  load_sec       in   SEC_W  seconds load value
//  load_min       in   MIN_W  minutes load value
//  load_hr        in   HR_W   hours load value
//  r_sec          out  SEC_W  current seconds
//  r_min          out  MIN_W  current minutes
//  r_hr           out  HR_W   current hours
//  sec_p          out  1      1-cycle pulse per applied tick
//  carry_for_min  out  1      1-cycle pulse when seconds wrap (up 59->0 / down 0->59)
//  ovf_p          out  1      1-cycle pulse on up-mode wrap of HR_MOD-1:MIN_MOD-1:SEC_MOD-1 -> 0:0:0
//  done           out  1      sticky: countdown reached 0:0:0
//  done_p         out  1      1-cycle pulse on the edge done is set
// BEHAVIOUR
//  - All outputs registered. rst_n=0: prescaler, fields, all pulses, done <= 0.
//  - Priority per edge: rst_n > clear > load > tick. clear/load: prescaler <= 0, done <= 0, pulses 0.
//  - load clamps each field: value >= modulus loads modulus-1 (e.g. load_sec=63 -> 59).
//  - Prescaler 0..DIV-1 advances only when enable=1 and not halted; holds (not reset) when enable=0.
//  - Tick = edge where prescaler==DIV-1 and enable=1: prescaler <= 0, fields update on that same edge,
//    sec_p <= 1; pulses therefore visible in the cycle after the tick edge, aligned with new field values.
//  - All pulse outputs default 0 every edge unless set by that edge.
//  - Up: sec+1; at SEC_MOD-1 -> 0 with carry_for_min, min+1; min at MIN_MOD-1 -> 0, hr+1;
//    hr at HR_MOD-1 -> 0 and ovf_p. Up mode never sets done.
//  - Down: sec-1; at 0 -> SEC_MOD-1 with carry_for_min (borrow), min-1; min 0 -> MIN_MOD-1, hr-1.
//    Tick that produces 0:0:0 sets done=1, done_p=1. While done=1 and mode=1: halted, prescaler and
//    fields hold, no sec_p. Down tick starting at 0:0:0 with done=0 (e.g. after load of zero):
//    no field change, sets done/done_p, no sec_p.
//  - mode change takes effect at the next tick; prescaler not disturbed. Switching to up while done=1
//    resumes counting; done stays 1 until clear/load.
//  - Field updates use a single cascaded decision per tick; no intermediate out-of-range values ever visible.
// STRUCTURE
//  - timer_pkg: mode_e {MODE_UP, MODE_DOWN}, helper function clamp(value, modulus).
//  - Sub-module mod_counter #(MOD): one field with inc/dec/load/clear, outputs value and wrap pulse;
//    three instances chained by wrap -> next field inc/dec. Prescaler and done logic in timer_core.
// TESTING  (CLK_HZ=4, TICK_HZ=1 -> DIV=4 unless noted)
//  1 rst_n=0 2 cycles, enable=1 -> all outputs 0; after release sec_p first high after 4th edge, r_sec=1.
//  2 load 0:59:58, up -> after 2 ticks r=1:00:00, carry_for_min 1 cycle aligned with r_sec=0.
//  3 load 23:59:59, up -> 1 tick -> 0:00:00, ovf_p=1 exactly one cycle, done stays 0.
//  4 load 0:01:01, down -> 61st tick r=0:0:0, done=1, done_p 1 cycle; 8 more cycles: no sec_p, fields hold.
//  5 load_sec=63, load_min=60, load_hr=30 -> r=23:59:59; clear+load same edge -> r=0:0:0.
//  6 enable=0 for 10 cycles with prescaler=2 -> fields hold, next sec_p exactly 10 cycles later than
//    unpaused; rst_n=0 mid-second -> immediate zeros, prescaler restarts at 0.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and helpers for the timer_core slice
// Purpose: count-direction enum and the load clamp used by every field counter.
package timer_pkg;

    typedef enum logic {
        MODE_UP   = 1'b0,
        MODE_DOWN = 1'b1
    } mode_e;

    // Out-of-range load values saturate to the field's largest legal value.
    function automatic int clamp(input int value, input int modulus);
        return (value >= modulus) ? modulus - 1 : value;
    endfunction

endpackage

// File: rtl/timer_core_if.sv
// rtl/timer_core_if.sv - control/status bundle between a timer and its user
// Purpose: groups the timer controls, load values and registered status.
// Ports (slave = timer side):
//   in : enable, mode, clear, load, load_sec, load_min, load_hr
//   out: r_sec, r_min, r_hr, sec_p, carry_for_min, ovf_p, done, done_p
interface timer_core_if #(
    parameter int SEC_W = 6,
    parameter int MIN_W = 6,
    parameter int HR_W  = 5
);
    logic             enable;
    logic             mode;
    logic             clear;
    logic             load;
    logic [SEC_W-1:0] load_sec;
    logic [MIN_W-1:0] load_min;
    logic [HR_W-1:0]  load_hr;
    logic [SEC_W-1:0] r_sec;
    logic [MIN_W-1:0] r_min;
    logic [HR_W-1:0]  r_hr;
    logic             sec_p;
    logic             carry_for_min;
    logic             ovf_p;
    logic             done;
    logic             done_p;

    modport slave (
        input  enable, mode, clear, load, load_sec, load_min, load_hr,
        output r_sec, r_min, r_hr, sec_p, carry_for_min, ovf_p, done, done_p
    );

    modport master (
        output enable, mode, clear, load, load_sec, load_min, load_hr,
        input  r_sec, r_min, r_hr, sec_p, carry_for_min, ovf_p, done, done_p
    );
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - one modulo-MOD time field
// Purpose: register holding 0..MOD-1 with clear > load > inc > dec priority.
// Ports: mclk, rst_n, clear, load, load_val, inc, dec -> value, wrap
//   wrap is combinational so the next field can step on the same edge.
module mod_counter #(
    parameter int MOD = 60,
    parameter int W   = $clog2(MOD)
) (
    input  logic         mclk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         wrap
);
    import timer_pkg::*;

    localparam logic [W-1:0] TOP = W'(MOD - 1);

    assign wrap = (inc && value == TOP) || (dec && value == '0);

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (load) begin
            value <= W'(clamp(int'(load_val), MOD));
        end else if (inc) begin
            value <= (value == TOP) ? '0 : value + 1'b1;
        end else if (dec) begin
            value <= (value == '0) ? TOP : value - 1'b1;
        end
    end
endmodule

// File: rtl/timer_core.sv
// rtl/timer_core.sv - prescaled sec/min/hour up/down timer
// Purpose: prescaler producing ticks at TICK_HZ, three cascaded field counters,
//   overflow, done and per-tick pulse reporting.
// Ports: mclk, rst_n (sync, active low), bus (timer_core_if.slave).
module timer_core #(
    parameter int CLK_HZ  = 32_000_000,
    parameter int TICK_HZ = 1,
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 60,
    parameter int HR_MOD  = 24
) (
    input  logic        mclk,
    input  logic        rst_n,
    timer_core_if.slave bus
);
    import timer_pkg::*;

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PW    = $clog2(DIV);
    localparam int SEC_W = $clog2(SEC_MOD);
    localparam int MIN_W = $clog2(MIN_MOD);
    localparam int HR_W  = $clog2(HR_MOD);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    logic [PW-1:0]    presc;
    logic             done_q;
    logic             sec_p_q, carry_q, ovf_q, done_p_q;
    logic [SEC_W-1:0] sec_v;
    logic [MIN_W-1:0] min_v;
    logic [HR_W-1:0]  hr_v;
    logic             sec_wrap, min_wrap, hr_wrap;
    mode_e            cur_mode;
    logic             down, advance, tick, at_zero, step, hits_zero;

    assign cur_mode  = mode_e'(bus.mode);
    assign down      = (cur_mode == MODE_DOWN);
    // A finished countdown freezes everything until cleared, reloaded or switched to up.
    assign advance   = bus.enable && !(done_q && down);
    assign tick      = advance && (presc == PRESC_LAST) && !bus.clear && !bus.load;
    assign at_zero   = (sec_v == '0) && (min_v == '0) && (hr_v == '0);
    // Counting down from 0:0:0 only raises done; the fields must not wrap.
    assign step      = tick && !(down && at_zero);
    assign hits_zero = (sec_v == SEC_W'(1)) && (min_v == '0) && (hr_v == '0);

    mod_counter #(.MOD(SEC_MOD), .W(SEC_W)) u_sec (
        .mclk(mclk), .rst_n(rst_n), .clear(bus.clear), .load(bus.load),
        .load_val(bus.load_sec), .inc(step && !down), .dec(step && down),
        .value(sec_v), .wrap(sec_wrap)
    );

    mod_counter #(.MOD(MIN_MOD), .W(MIN_W)) u_min (
        .mclk(mclk), .rst_n(rst_n), .clear(bus.clear), .load(bus.load),
        .load_val(bus.load_min), .inc(sec_wrap && !down), .dec(sec_wrap && down),
        .value(min_v), .wrap(min_wrap)
    );

    mod_counter #(.MOD(HR_MOD), .W(HR_W)) u_hr (
        .mclk(mclk), .rst_n(rst_n), .clear(bus.clear), .load(bus.load),
        .load_val(bus.load_hr), .inc(min_wrap && !down), .dec(min_wrap && down),
        .value(hr_v), .wrap(hr_wrap)
    );

    always_ff @(posedge mclk) begin
        if (!rst_n) begin
            presc    <= '0;
            done_q   <= 1'b0;
            sec_p_q  <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_p_q <= 1'b0;
        end else begin
            sec_p_q  <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_p_q <= 1'b0;
            if (bus.clear || bus.load) begin
                presc  <= '0;
                done_q <= 1'b0;
            end else if (advance) begin
                presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
                if (tick) begin
                    if (down && at_zero) begin
                        done_q   <= 1'b1;
                        done_p_q <= 1'b1;
                    end else begin
                        sec_p_q <= 1'b1;
                        carry_q <= sec_wrap;
                        ovf_q   <= !down && hr_wrap;
                        if (down && hits_zero) begin
                            done_q   <= 1'b1;
                            done_p_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign bus.r_sec         = sec_v;
    assign bus.r_min         = min_v;
    assign bus.r_hr          = hr_v;
    assign bus.sec_p         = sec_p_q;
    assign bus.carry_for_min = carry_q;
    assign bus.ovf_p         = ovf_q;
    assign bus.done          = done_q;
    assign bus.done_p        = done_p_q;
endmodule

// File: tb/tb_timer_core.sv
// tb/tb_timer_core.sv - self-checking bench for timer_core against a total-seconds model
module tb_timer_core;
    localparam int DIV = 4;
    localparam int NSEC = 24 * 60 * 60;

    logic mclk = 1'b0;
    logic rst_n;
    always #5 mclk = ~mclk;

    timer_core_if #(.SEC_W(6), .MIN_W(6), .HR_W(5)) ifc ();

    timer_core #(
        .CLK_HZ(4), .TICK_HZ(1), .SEC_MOD(60), .MIN_MOD(60), .HR_MOD(24)
    ) dut (
        .mclk(mclk),
        .rst_n(rst_n),
        .bus(ifc)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the time is one integer of seconds-of-day; fields are derived by division.
    int m_p = 0;
    int m_t = 0;
    bit m_done = 0, m_sec_p = 0, m_carry = 0, m_ovf = 0, m_done_p = 0;

    function automatic int lim(input int v, input int m);
        return (v >= m) ? m - 1 : v;
    endfunction

    always @(posedge mclk) begin
        int p, t;
        bit d, sp, cy, ov, dp;
        p = m_p; t = m_t; d = m_done;
        sp = 0; cy = 0; ov = 0; dp = 0;
        if (!rst_n || ifc.clear) begin
            p = 0; t = 0; d = 0;
        end else if (ifc.load) begin
            p = 0; d = 0;
            t = lim(int'(ifc.load_hr), 24) * 3600 + lim(int'(ifc.load_min), 60) * 60
                + lim(int'(ifc.load_sec), 60);
        end else if (ifc.enable && !(d && ifc.mode)) begin
            if (p == DIV - 1) begin
                p = 0;
                if (!ifc.mode) begin
                    sp = 1; cy = (t % 60 == 59); ov = (t == NSEC - 1);
                    t = (t + 1) % NSEC;
                end else if (t == 0) begin
                    d = 1; dp = 1;
                end else begin
                    sp = 1; cy = (t % 60 == 0);
                    t = t - 1;
                    if (t == 0) begin d = 1; dp = 1; end
                end
            end else begin
                p = p + 1;
            end
        end
        m_p <= p; m_t <= t; m_done <= d;
        m_sec_p <= sp; m_carry <= cy; m_ovf <= ov; m_done_p <= dp;
    end

    always @(negedge mclk) begin
        chk("r_sec", 32'(ifc.r_sec), 32'(m_t % 60));
        chk("r_min", 32'(ifc.r_min), 32'((m_t / 60) % 60));
        chk("r_hr", 32'(ifc.r_hr), 32'(m_t / 3600));
        chk("sec_p", 32'(ifc.sec_p), 32'(m_sec_p));
        chk("carry_for_min", 32'(ifc.carry_for_min), 32'(m_carry));
        chk("ovf_p", 32'(ifc.ovf_p), 32'(m_ovf));
        chk("done", 32'(ifc.done), 32'(m_done));
        chk("done_p", 32'(ifc.done_p), 32'(m_done_p));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic do_load(input int h, input int m, input int s);
        ifc.load = 1; ifc.load_hr = 5'(h); ifc.load_min = 6'(m); ifc.load_sec = 6'(s);
        @(negedge mclk);
        ifc.load = 0;
    endtask

    // Returns at the negedge where the n-th sec_p is seen; an expired bound is a failure.
    task automatic wait_ticks(input int n, input string name);
        int seen = 0;
        int budget = n * DIV * 3 + 20;
        while (seen < n && budget > 0) begin
            @(negedge mclk);
            if (ifc.sec_p === 1'b1) seen++;
            budget--;
        end
        chk({name, "_ticks_seen"}, 32'(seen), 32'(n));
    endtask

    // Negedges until sec_p is seen (bounded).
    task automatic cycles_to_tick(output int n);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (ifc.sec_p !== 1'b1 && n < 40);
    endtask

    initial begin
        int n, cnt;
        rst_n = 0;
        ifc.enable = 1; ifc.mode = 0; ifc.clear = 0; ifc.load = 0;
        ifc.load_sec = '0; ifc.load_min = '0; ifc.load_hr = '0;
        cyc(2);
        chk("reset_r_sec", 32'(ifc.r_sec), 0);
        chk("reset_done", 32'(ifc.done), 0);
        chk("reset_sec_p", 32'(ifc.sec_p), 0);
        rst_n = 1;
        cycles_to_tick(n);
        chk("first_tick_latency", 32'(n), 4);
        chk("first_tick_r_sec", 32'(ifc.r_sec), 1);

        // Minute carry into hour.
        do_load(0, 59, 58);
        wait_ticks(2, "carry");
        chk("carry_hr", 32'(ifc.r_hr), 1);
        chk("carry_min", 32'(ifc.r_min), 0);
        chk("carry_sec", 32'(ifc.r_sec), 0);
        chk("carry_pulse", 32'(ifc.carry_for_min), 1);

        // Day overflow.
        do_load(23, 59, 59);
        wait_ticks(1, "ovf");
        chk("ovf_pulse", 32'(ifc.ovf_p), 1);
        chk("ovf_r_hr", 32'(ifc.r_hr), 0);
        chk("ovf_done", 32'(ifc.done), 0);
        cyc(1);
        chk("ovf_one_cycle", 32'(ifc.ovf_p), 0);

        // Countdown to zero and halt.
        ifc.mode = 1;
        do_load(0, 1, 1);
        wait_ticks(61, "down");
        chk("down_done", 32'(ifc.done), 1);
        chk("down_done_p", 32'(ifc.done_p), 1);
        chk("down_r_min", 32'(ifc.r_min), 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            if (ifc.sec_p === 1'b1) cnt++;
        end
        chk("halt_no_sec_p", 32'(cnt), 0);
        chk("halt_r_sec", 32'(ifc.r_sec), 0);

        // Loading zero then counting down: done without sec_p.
        do_load(0, 0, 0);
        cyc(DIV);
        chk("zero_load_done", 32'(ifc.done_p), 1);

        // Resume in up mode while done stays set.
        ifc.mode = 0;
        wait_ticks(2, "resume");
        chk("resume_r_sec", 32'(ifc.r_sec), 2);
        chk("resume_done_sticky", 32'(ifc.done), 1);

        // Clamp, then clear beating load.
        do_load(30, 60, 63);
        chk("clamp_hr", 32'(ifc.r_hr), 23);
        chk("clamp_min", 32'(ifc.r_min), 59);
        chk("clamp_sec", 32'(ifc.r_sec), 59);
        ifc.clear = 1; ifc.load = 1;
        @(negedge mclk);
        ifc.clear = 0; ifc.load = 0;
        chk("clear_over_load_hr", 32'(ifc.r_hr), 0);
        chk("clear_over_load_sec", 32'(ifc.r_sec), 0);

        // Pause with prescaler at 2.
        cyc(2);
        ifc.enable = 0;
        cyc(10);
        chk("pause_hold_sec", 32'(ifc.r_sec), 0);
        ifc.enable = 1;
        cycles_to_tick(n);
        chk("pause_delay", 32'(n + 10), 12);

        // Reset mid-second.
        do_load(5, 5, 5);
        cyc(2);
        rst_n = 0;
        @(negedge mclk);
        chk("midreset_hr", 32'(ifc.r_hr), 0);
        chk("midreset_sec", 32'(ifc.r_sec), 0);
        rst_n = 1;
        cycles_to_tick(n);
        chk("midreset_latency", 32'(n), 4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            ifc.clear  = (r < 1);
            ifc.load   = (r >= 1 && r < 4);
            ifc.enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 99) < 3) ifc.mode = ~ifc.mode;
            if ($urandom_range(0, 1) == 1) begin
                ifc.load_hr = 5'($urandom_range(0, 31));
                ifc.load_min = 6'($urandom_range(0, 63));
                ifc.load_sec = 6'($urandom_range(0, 63));
            end else begin
                ifc.load_hr = (r < 2) ? 5'd23 : 5'd0;
                ifc.load_min = (r < 2) ? 6'd59 : 6'($urandom_range(0, 1));
                ifc.load_sec = 6'($urandom_range(0, 3));
            end
            @(negedge mclk);
        end
        ifc.clear = 0; ifc.load = 0;

        @(posedge mclk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
